// File: rtl/fifo_pkg.sv
// Shared definitions for the flagged FIFO family.
// Contents: default widths, read-mode constants, the flag register layout
// and a helper that sizes the occupancy counter.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH_DEF = 64;
  localparam int unsigned FIFO_ADDR_WIDTH_DEF = 4;

  // Read-mode selector values for the FWFT parameter.
  localparam int unsigned FIFO_MODE_REG  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Registered status flags presented to the consumer.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_flags_t;

  localparam fifo_flags_t FIFO_FLAGS_RST = '{
    empty:        1'b1,
    full:         1'b0,
    almost_empty: 1'b1,
    almost_full:  1'b0,
    overflow:     1'b0,
    underflow:    1'b0
  };

  // Occupancy spans 0..2**addr_width inclusive, so one extra bit is needed.
  function automatic int unsigned count_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_flagged_if.sv
// Handshake/status bundle between a producer/consumer and fifo_flagged.
// master: drives enq, deq, data_in; observes data_out, count and flags.
// slave:  the FIFO side (inverse directions).
interface fifo_flagged_if
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) ();

  localparam int unsigned CW = count_width(ADDR_WIDTH);

  logic                  enq;
  logic                  deq;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output enq, deq, data_in,
    input  data_out, empty, full, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  enq, deq, data_in,
    output data_out, empty, full, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-around pointer with synchronous active-high reset and increment enable.
// Ports: clk, reset, inc_i (advance by one at the edge), ptr_o (current value).
module fifo_ptr #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  // Natural binary wrap from 2**ADDR_WIDTH-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_flagged.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty flags,
// overflow/underflow pulses and a registered or show-ahead read port.
// Ports: clk, reset (synchronous, active-high), bus (fifo_flagged_if.slave):
//   enq/deq/data_in in; data_out, count, empty, full, almost_full,
//   almost_empty, overflow, underflow out (all registered).
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
  parameter int unsigned FWFT       = FIFO_MODE_REG,
  parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic          clk,
  input  logic          reset,
  fifo_flagged_if.slave bus
);

  localparam int unsigned FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW         = count_width(ADDR_WIDTH);

  // Reject illegal threshold / mode combinations at elaboration.
  if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH && AF_THRESH <= FIFO_DEPTH))
  begin : g_bad_thresh
    $error("fifo_flagged: need 0 < AE_THRESH < AF_THRESH <= FIFO_DEPTH");
  end
  if (FWFT > FIFO_MODE_FWFT) begin : g_bad_mode
    $error("fifo_flagged: FWFT must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  fifo_flags_t           flags_q, flags_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rd_acc;
  logic                  wr_acc;

  // A full FIFO still takes a write when the same cycle's read frees a slot.
  assign rd_acc = bus.deq && !flags_q.empty;
  assign wr_acc = bus.enq && (!flags_q.full || rd_acc);

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (wr_acc),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (rd_acc),
    .ptr_o (rd_ptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr] <= bus.data_in;
  end

  // Next occupancy, flags and read data; flags track the post-edge count.
  always_comb begin
    count_d = count_q;
    flags_d = flags_q;
    dout_d  = dout_q;

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    flags_d.empty        = (count_d == '0);
    flags_d.full         = (count_d == CW'(FIFO_DEPTH));
    flags_d.almost_full  = (count_d >= CW'(AF_THRESH));
    flags_d.almost_empty = (count_d <= CW'(AE_THRESH));
    flags_d.overflow     = bus.enq && !wr_acc;
    flags_d.underflow    = bus.deq && !rd_acc;

    if (FWFT == FIFO_MODE_FWFT) begin
      // Register the word that will be at the head after this edge.
      if (count_d == '0)
        dout_d = '0;
      else if (rd_acc)
        dout_d = (count_q == CW'(1)) ? bus.data_in : mem[rd_ptr + ADDR_WIDTH'(1)];
      else if (flags_q.empty)
        dout_d = bus.data_in;
    end else begin
      if (rd_acc) dout_d = mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      flags_q <= FIFO_FLAGS_RST;
      dout_q  <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.data_out     = dout_q;
  assign bus.count        = count_q;
  assign bus.empty        = flags_q.empty;
  assign bus.full         = flags_q.full;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.overflow     = flags_q.overflow;
  assign bus.underflow    = flags_q.underflow;

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: one registered-read and one show-ahead instance
// share the same stimulus; a queue-based reference predicts every cycle.
module tb_fifo_flagged;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 4;
  localparam int          DEPTH = 16;
  localparam int          AF    = DEPTH - 2;
  localparam int          AE    = 2;

  typedef struct {
    int           count;
    bit           empty, full, af, ae, of, uf;
    logic [DW-1:0] d0, d1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enq = 1'b0;
  logic deq = 1'b0;
  logic [DW-1:0] din = '0;

  int errors = 0;
  int checks = 0;

  exp_t          expq [$];
  logic [DW-1:0] mq [$];
  logic [DW-1:0] dreg;
  exp_t          e;

  always #5 clk = ~clk;

  fifo_flagged_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_reg ();
  fifo_flagged_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if_fw ();

  assign if_reg.enq = enq;  assign if_reg.deq = deq;  assign if_reg.data_in = din;
  assign if_fw.enq  = enq;  assign if_fw.deq  = deq;  assign if_fw.data_in  = din;

  fifo_flagged #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_reg (
    .clk(clk), .reset(rst), .bus(if_reg));
  fifo_flagged #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_fw (
    .clk(clk), .reset(rst), .bus(if_fw));

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the FIFO is a plain queue; drive inputs, predict post-edge state.
  task automatic step(input bit ve, input bit vd, input bit vr, input logic [DW-1:0] vdin);
    bit   rd, wr;
    exp_t x;
    enq = ve; deq = vd; rst = vr; din = vdin;
    if (vr) begin
      mq.delete();
      dreg = '0;
      x.of = 0; x.uf = 0;
    end else begin
      rd = vd && (mq.size() > 0);
      wr = ve && ((mq.size() < DEPTH) || rd);
      x.of = ve && !wr;
      x.uf = vd && !rd;
      if (rd) dreg = mq.pop_front();
      if (wr) mq.push_back(vdin);
    end
    x.count = mq.size();
    x.empty = (x.count == 0);
    x.full  = (x.count == DEPTH);
    x.af    = (x.count >= AF);
    x.ae    = (x.count <= AE);
    x.d0    = dreg;
    x.d1    = (x.count > 0) ? mq[0] : '0;
    expq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("reg.count",    64'(if_reg.count),        64'(e.count));
      chk("reg.empty",    64'(if_reg.empty),        64'(e.empty));
      chk("reg.full",     64'(if_reg.full),         64'(e.full));
      chk("reg.afull",    64'(if_reg.almost_full),  64'(e.af));
      chk("reg.aempty",   64'(if_reg.almost_empty), 64'(e.ae));
      chk("reg.overflow", 64'(if_reg.overflow),     64'(e.of));
      chk("reg.underflow",64'(if_reg.underflow),    64'(e.uf));
      chk("reg.data_out", if_reg.data_out,          e.d0);
      chk("fw.count",     64'(if_fw.count),         64'(e.count));
      chk("fw.empty",     64'(if_fw.empty),         64'(e.empty));
      chk("fw.full",      64'(if_fw.full),          64'(e.full));
      chk("fw.afull",     64'(if_fw.almost_full),   64'(e.af));
      chk("fw.aempty",    64'(if_fw.almost_empty),  64'(e.ae));
      chk("fw.overflow",  64'(if_fw.overflow),      64'(e.of));
      chk("fw.underflow", 64'(if_fw.underflow),     64'(e.uf));
      chk("fw.data_out",  if_fw.data_out,           e.d1);
    end
  end

  initial begin
    dreg = '0;
    // Reset then fill past full.
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, DW'(8'h10 + i));
    step(1, 0, 0, DW'(8'h99));
    step(0, 0, 0, '0);
    // Drain in order, then underflow.
    for (int i = 0; i < 16; i++) step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    // Simultaneous enq/deq at full and at empty.
    for (int i = 0; i < 16; i++) step(1, 0, 0, {$urandom, $urandom});
    step(1, 1, 0, DW'(8'hAA));
    for (int i = 0; i < 16; i++) step(0, 1, 0, '0);
    step(1, 1, 0, DW'(8'h55));
    step(0, 1, 0, '0);
    // Single-word ping-pong across several pointer wraps.
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, DW'(12'hC00 + i));
      step(0, 1, 0, '0);
    end
    // Show-ahead sequence.
    step(0, 0, 1, '0);
    step(1, 0, 0, DW'(8'h33));
    step(0, 0, 0, '0);
    step(1, 0, 0, DW'(8'h44));
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    // Mid-stream reset with a concurrent enq, then a round trip.
    for (int i = 0; i < 5; i++) step(1, 0, 0, DW'(8'h60 + i));
    step(1, 0, 1, DW'(8'h77));
    step(1, 0, 0, DW'(8'h88));
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    // Random traffic, biased to visit full then empty.
    for (int i = 0; i < 400; i++) begin
      bit re, rdq, rr;
      re  = ($urandom_range(99) < ((i < 200) ? 75 : 35));
      rdq = ($urandom_range(99) < ((i < 200) ? 35 : 75));
      rr  = ($urandom_range(199) == 0);
      step(re, rdq, rr, {$urandom, $urandom});
    end
    step(0, 0, 0, '0);
    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
